// File: rtl/ex_stage_pkg.sv
// Shared types, opcode/result-class encodings and divider state for the EX stage.
package ex_stage_pkg;

  typedef logic [7:0]  AluOp_t;
  typedef logic [2:0]  AluSel_t;
  typedef logic [31:0] Reg_t;
  typedef logic [4:0]  RegAddr_t;

  localparam AluOp_t EXE_NOP_OP  = 8'b0000_0000;
  localparam AluOp_t EXE_AND_OP  = 8'b0010_0100;
  localparam AluOp_t EXE_OR_OP   = 8'b0010_0101;
  localparam AluOp_t EXE_XOR_OP  = 8'b0010_0110;
  localparam AluOp_t EXE_NOR_OP  = 8'b0010_0111;
  localparam AluOp_t EXE_SLL_OP  = 8'b0111_1100;
  localparam AluOp_t EXE_SRL_OP  = 8'b0000_0010;
  localparam AluOp_t EXE_SRA_OP  = 8'b0000_0011;
  localparam AluOp_t EXE_SLT_OP  = 8'b0010_1010;
  localparam AluOp_t EXE_SLTU_OP = 8'b0010_1011;
  localparam AluOp_t EXE_ADDU_OP = 8'b0010_0001;
  localparam AluOp_t EXE_SUBU_OP = 8'b0010_0011;
  localparam AluOp_t EXE_DIV_OP  = 8'b0001_1010;
  localparam AluOp_t EXE_DIVU_OP = 8'b0001_1011;

  localparam AluSel_t EXE_RES_NOP   = 3'b000;
  localparam AluSel_t EXE_RES_LOGIC = 3'b001;
  localparam AluSel_t EXE_RES_SHIFT = 3'b010;
  localparam AluSel_t EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_FREE,
    DIV_BY_ZERO,
    DIV_ON,
    DIV_END
  } DivState_t;

  localparam Reg_t ZeroWord = '0;

  function automatic Reg_t neg32(input Reg_t v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring divider: one quotient bit per cycle, sign fix-up on the DIV_END output.
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic        i_annul,
  input  Reg_t        i_opdata1,
  input  Reg_t        i_opdata2,
  output logic [63:0] o_result,
  output logic        o_ready
);

  localparam int unsigned CW = $clog2(DIV_STEPS + 1);

  DivState_t   r_state;
  logic [63:0] r_acc;
  Reg_t        r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [CW-1:0] r_cnt;

  Reg_t        w_a_abs;
  Reg_t        w_b_abs;
  logic [64:0] w_sh;
  logic [32:0] w_diff;
  logic [63:0] w_step;
  Reg_t        w_quo;
  Reg_t        w_rem;

  always_comb begin
    w_a_abs = (i_signed && i_opdata1[31]) ? neg32(i_opdata1) : i_opdata1;
    w_b_abs = (i_signed && i_opdata2[31]) ? neg32(i_opdata2) : i_opdata2;
  end

  // {rem, quot} shifted one bit wider so the remainder's carry-out takes part in the compare.
  always_comb begin
    w_sh   = {r_acc, 1'b0};
    w_diff = w_sh[64:32] - {1'b0, r_divisor};
    if (!w_diff[32]) w_step = {w_diff[31:0], w_sh[31:1], 1'b1};
    else             w_step = w_sh[63:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DIV_FREE;
      r_acc     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_cnt     <= '0;
    end else if (i_annul) begin
      r_state <= DIV_FREE;
    end else begin
      unique case (r_state)
        DIV_FREE: begin
          if (i_start) begin
            if (i_opdata2 == ZeroWord) begin
              r_state <= DIV_BY_ZERO;
            end else begin
              r_acc     <= {ZeroWord, w_a_abs};
              r_divisor <= w_b_abs;
              r_neg_q   <= i_signed && (i_opdata1[31] ^ i_opdata2[31]);
              r_neg_r   <= i_signed && i_opdata1[31];
              r_cnt     <= '0;
              r_state   <= DIV_ON;
            end
          end
        end
        DIV_BY_ZERO: begin
          r_acc   <= '0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
          r_state <= DIV_END;
        end
        DIV_ON: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(DIV_STEPS - 1)) r_state <= DIV_END;
        end
        DIV_END: r_state <= DIV_FREE;
        default: r_state <= DIV_FREE;
      endcase
    end
  end

  always_comb begin
    w_quo    = r_neg_q ? neg32(r_acc[31:0])  : r_acc[31:0];
    w_rem    = r_neg_r ? neg32(r_acc[63:32]) : r_acc[63:32];
    o_ready  = (r_state == DIV_END);
    o_result = o_ready ? {w_rem, w_quo} : '0;
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU and result mux plus the stalling divider.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush_i,
  input  AluOp_t   aluop_i,
  input  AluSel_t  alusel_i,
  input  Reg_t     reg1_i,
  input  Reg_t     reg2_i,
  input  RegAddr_t wd_i,
  input  logic     wreg_i,
  output RegAddr_t wd_o,
  output logic     wreg_o,
  output Reg_t     wdata_o,
  output logic     whilo_o,
  output Reg_t     hi_o,
  output Reg_t     lo_o,
  output logic     stallreq_o
);

  logic        w_is_div;
  logic        w_div_signed;
  logic        w_div_ready;
  logic [63:0] w_div_result;
  Reg_t        w_logic;
  Reg_t        w_shift;
  Reg_t        w_arith;
  Reg_t        w_sel;

  assign w_is_div     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign w_div_signed = (aluop_i == EXE_DIV_OP);

  div_unit #(.DIV_STEPS(DIV_STEPS)) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_is_div && !flush_i),
    .i_signed  (w_div_signed),
    .i_annul   (flush_i),
    .i_opdata1 (reg1_i),
    .i_opdata2 (reg2_i),
    .o_result  (w_div_result),
    .o_ready   (w_div_ready)
  );

  always_comb begin
    w_logic = ZeroWord;
    w_shift = ZeroWord;
    w_arith = ZeroWord;
    unique case (aluop_i)
      EXE_OR_OP:   w_logic = reg1_i | reg2_i;
      EXE_AND_OP:  w_logic = reg1_i & reg2_i;
      EXE_XOR_OP:  w_logic = reg1_i ^ reg2_i;
      EXE_NOR_OP:  w_logic = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  w_shift = reg1_i << reg2_i[4:0];
      EXE_SRL_OP:  w_shift = reg1_i >> reg2_i[4:0];
      EXE_SRA_OP:  w_shift = Reg_t'($signed(reg1_i) >>> reg2_i[4:0]);
      EXE_ADDU_OP: w_arith = reg1_i + reg2_i;
      EXE_SUBU_OP: w_arith = reg1_i - reg2_i;
      EXE_SLT_OP:  w_arith = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP: w_arith = {31'd0, reg1_i < reg2_i};
      default: ;
    endcase
  end

  always_comb begin
    unique case (alusel_i)
      EXE_RES_LOGIC: w_sel = w_logic;
      EXE_RES_SHIFT: w_sel = w_shift;
      EXE_RES_ARITH: w_sel = w_arith;
      default:       w_sel = ZeroWord;
    endcase
  end

  // The ALU result is forced to zero while reset is held so nothing leaks into EX/MEM.
  assign wd_o       = wd_i;
  assign wreg_o     = wreg_i && !w_is_div;
  assign wdata_o    = rst ? w_sel : ZeroWord;
  assign whilo_o    = w_div_ready && !flush_i;
  assign hi_o       = w_div_result[63:32];
  assign lo_o       = w_div_result[31:0];
  assign stallreq_o = rst && w_is_div && !w_div_ready && !flush_i;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU vectors, divider latency/results, flush and reset abort.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic     clk;
  logic     rst;
  logic     flush_i;
  AluOp_t   aluop_i;
  AluSel_t  alusel_i;
  Reg_t     reg1_i;
  Reg_t     reg2_i;
  RegAddr_t wd_i;
  logic     wreg_i;
  RegAddr_t wd_o;
  logic     wreg_o;
  Reg_t     wdata_o;
  logic     whilo_o;
  Reg_t     hi_o;
  Reg_t     lo_o;
  logic     stallreq_o;

  int n_chk  = 0;
  int n_fail = 0;

  ex_stage #(.DIV_STEPS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input AluOp_t op, input AluSel_t sel, input Reg_t a, input Reg_t b);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
  endtask

  task automatic alu(input string tag, input AluOp_t op, input AluSel_t sel,
                     input Reg_t a, input Reg_t b, input Reg_t exp);
    drive(op, sel, a, b);
    #1;
    chk(tag, wdata_o, exp);
  endtask

  // Issue a divide at the start of cycle T; expect stall for n_stall cycles, then the HI/LO write.
  task automatic do_div(input string tag, input AluOp_t op, input Reg_t a, input Reg_t b,
                        input int n_stall, input Reg_t exp_lo, input Reg_t exp_hi);
    int bad_stall;
    int bad_whilo;
    @(posedge clk); #1;
    drive(op, EXE_RES_NOP, a, b);
    wreg_i = 1'b1;
    bad_stall = 0;
    bad_whilo = 0;
    for (int i = 0; i < n_stall; i++) begin
      @(negedge clk);
      if (stallreq_o !== 1'b1) bad_stall++;
      if (whilo_o !== 1'b0) bad_whilo++;
      @(posedge clk); #1;
    end
    chk({tag, " stall-window"}, 32'(bad_stall), 32'd0);
    chk({tag, " whilo-early"}, 32'(bad_whilo), 32'd0);
    @(negedge clk);
    chk({tag, " stall-end"}, {31'd0, stallreq_o}, 32'd0);
    chk({tag, " whilo"}, {31'd0, whilo_o}, 32'd1);
    chk({tag, " lo"}, lo_o, exp_lo);
    chk({tag, " hi"}, hi_o, exp_hi);
    chk({tag, " wreg"}, {31'd0, wreg_o}, 32'd0);
    @(posedge clk); #1;
    drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0);
  endtask

  // Watch a window of idle cycles for any stray HI/LO write.
  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (whilo_o !== 1'b0) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst     = 1'b0;
    flush_i = 1'b0;
    wd_i    = 5'd9;
    wreg_i  = 1'b1;
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_00F0, 32'h0000_0F00);
    #12;
    chk("rst wdata", wdata_o, 32'h0);
    chk("rst hi", hi_o, 32'h0);
    chk("rst lo", lo_o, 32'h0);
    chk("rst whilo", {31'd0, whilo_o}, 32'd0);
    chk("rst wd", {27'd0, wd_o}, 32'd9);
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
    #1;
    chk("rst stall", {31'd0, stallreq_o}, 32'd0);
    drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0);
    @(negedge clk);
    rst = 1'b1;

    @(posedge clk); #1;
    alu("or", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0);
    chk("or wreg", {31'd0, wreg_o}, 32'd1);
    alu("and",  EXE_AND_OP,  EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
    alu("xor",  EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    alu("nor",  EXE_NOR_OP,  EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0000_00FF, 32'h0000_FF00);
    alu("sll",  EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010);
    alu("srl",  EXE_SRL_OP,  EXE_RES_SHIFT, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    alu("sra",  EXE_SRA_OP,  EXE_RES_SHIFT, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    alu("slt",  EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    alu("sltu", EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu("addu", EXE_ADDU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu("subu", EXE_SUBU_OP, EXE_RES_ARITH, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    alu("nop",  EXE_OR_OP,   EXE_RES_NOP,   32'h1234_5678, 32'h1111_1111, 32'h0000_0000);

    do_div("divu 100/7", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    do_div("div -7/2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_div("div min/-1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0);
    do_div("div 7/-2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
    do_div("div by 0", EXE_DIV_OP, 32'd55, 32'd0, 2, 32'h0, 32'h0);

    // Flush at T+10 of a divide.
    @(posedge clk); #1;
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
    quiet("flush pre whilo", 1);
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush stall", {31'd0, stallreq_o}, 32'd0);
    chk("flush whilo", {31'd0, whilo_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0);
    quiet("flush no whilo", 40);
    do_div("post-flush 9/3", EXE_DIVU_OP, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    // Reset asserted at T+5 of a divide.
    @(posedge clk); #1;
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst stall", {31'd0, stallreq_o}, 32'd0);
    chk("midrst whilo", {31'd0, whilo_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0);
    quiet("midrst no whilo", 40);
    do_div("post-rst 9/3", EXE_DIVU_OP, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
